cosim_commit_arbiter: RTL and testbench
=======================================

Name: cosim_commit_arbiter

Overview:
- Collects commit and trap records from NUM_HARTS cores into per-hart FIFOs.
- Merges them onto one serialized cosim trace port, one record per accepted cycle, in front of the Dromajo step/raise-trap DPI bridge.
- Keeps program order within each hart. Round-robin with bounded bursts across harts.
- Sits between the core trace taps and the simulation-only cosim blackbox. One clock domain.

Parameters:
- NUM_HARTS, 2, number of requesting harts (1..8)
- HARTID_LEN, 1, width of out_hartid; must be ≥ clog2(NUM_HARTS), minimum 1
- XLEN, 64, pc/wdata/cause width
- INST_BITS, 32, instruction width
- RD, 5, destination register index width
- DEPTH, 8, per-hart FIFO entries; power of two, ≥ 2
- BURST, 4, max consecutive grants to one hart before rotating; ≥ 1

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  NUM_HARTS  per-hart record valid
- in_ready  out  NUM_HARTS  per-hart FIFO not full
- in_kind  in  NUM_HARTS  0 = commit, 1 = trap
- in_pc  in  XLEN*NUM_HARTS  commit pc, hart h at bits [(h+1)*XLEN-1 -: XLEN]
- in_inst  in  INST_BITS*NUM_HARTS  instruction
- in_wdata  in  XLEN*NUM_HARTS  writeback data; holds the trap cause when kind = 1
- in_rd_valid  in  NUM_HARTS  wdata valid
- in_rd  in  RD*NUM_HARTS  destination register
- out_valid  out  1  serialized record valid
- out_ready  in  1  consumer accepts
- out_hartid  out  HARTID_LEN  source hart
- out_kind, out_pc, out_inst, out_wdata, out_rd_valid, out_rd  out  1/XLEN/INST_BITS/XLEN/1/RD  selected record fields
- stall_cycles  out  32  see Optional Feature

Behaviour:
- Enqueue
  - Hart h pushes when in_valid[h] & in_ready[h].
  - in_ready[h] = !full[h], a registered count compare.
  - A same-cycle pop does not raise in_ready.
  - Data is written on the clock edge. It is visible at the output no earlier than the next cycle, so minimum latency is 1 cycle.
- FIFO
  - Read/write pointers are clog2(DEPTH)+1 bits wide: full when MSBs differ and the rest are equal, empty when all bits are equal.
  - Push and pop in the same cycle on the same FIFO: count unchanged, both pointers advance.
  - Pointers wrap modulo 2*DEPTH.
- Output
  - out_valid = FIFO[grant] non-empty. All out_* fields come combinationally from the head of FIFO[grant]. out_hartid = grant.
  - Transfer happens on out_valid & out_ready; it pops FIFO[grant].
  - While out_valid & !out_ready, grant and all out_* fields hold stable. A no-switch rule applies.
- Arbiter state: grant register (0..NUM_HARTS-1) and burst_cnt (0..BURST-1).
- Grant update, evaluated each cycle:
  - IDLE (FIFO[grant] empty): grant moves to the first non-empty hart searching grant+1, grant+2, … cyclically. burst_cnt = 0. If all FIFOs are empty, nothing changes.
  - On transfer, if FIFO[grant] still holds ≥ 2 entries before the pop and burst_cnt < BURST-1: keep grant, burst_cnt++.
  - Otherwise on transfer: rotate to the next non-empty hart after grant, burst_cnt = 0. If no other hart is non-empty and FIFO[grant] is non-empty after the pop, keep grant with burst_cnt = 0.
- Trap records travel through the same FIFO as commits, so each trap is emitted after all earlier commits of its hart.
- Reset (asynchronous, any time)
  - All pointers, grant and burst_cnt go to 0. Queued records are discarded.
  - Reset values: out_valid = 0, in_ready = all 1, stall_cycles = 0.
  - FIFO storage is not reset. out_* data fields are don't-care while out_valid = 0.

Optional Feature:
- Macro: COSIM_COMMIT_ARBITER_STALL_CNT_EN.
- When defined:
  - stall_cycles increments by 1 on each cycle where any hart has in_valid & !in_ready.
  - It saturates at 0xFFFFFFFF and is cleared only by reset.
- When undefined: the port stays present, is tied to 0, and no counter flops exist.

Test Plan:
- Hart 0 pushes pc 0x80000000/4/8 on consecutive cycles, out_ready = 1 → out_valid from cycle 1; three records in order, out_hartid = 0, back-to-back.
- Both harts preloaded with 6 records, BURST = 2, out_ready = 1 → out_hartid sequence 0,0,1,1,0,0,1,1,0,0,1,1.
- out_ready = 0 and hart 1 pushes continuously → in_ready[1] falls after exactly 8 pushes; out_* stable for the whole hold; the first pop restores in_ready[1] on the following cycle.
- Hart 0 sends commit, commit, then trap with cause 0x8000000000000007 → trap emitted third with out_kind = 1 and out_wdata equal to the cause.
- Reset asserted mid-burst with 5 queued records → out_valid = 0 immediately (asynchronous); after release no stale record appears and grant = 0.
- Macro defined; hart 0 holds in_valid against a full FIFO for 10 cycles → stall_cycles = 10. Macro undefined → stall_cycles stays 0.

Source files
------------

// File: rtl/cosim_commit_arbiter.sv
// Per-hart commit/trap FIFOs merged onto one cosim trace port with bounded-burst round-robin.
// Optional saturating input-stall counter: define COSIM_COMMIT_ARBITER_STALL_CNT_EN.
module cosim_commit_arbiter #(
  parameter int NUM_HARTS  = 2,
  parameter int HARTID_LEN = 1,
  parameter int XLEN       = 64,
  parameter int INST_BITS  = 32,
  parameter int RD         = 5,
  parameter int DEPTH      = 8,
  parameter int BURST      = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_HARTS-1:0]           in_valid,
  output logic [NUM_HARTS-1:0]           in_ready,
  input  logic [NUM_HARTS-1:0]           in_kind,
  input  logic [XLEN*NUM_HARTS-1:0]      in_pc,
  input  logic [INST_BITS*NUM_HARTS-1:0] in_inst,
  input  logic [XLEN*NUM_HARTS-1:0]      in_wdata,
  input  logic [NUM_HARTS-1:0]           in_rd_valid,
  input  logic [RD*NUM_HARTS-1:0]        in_rd,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [HARTID_LEN-1:0]          out_hartid,
  output logic                           out_kind,
  output logic [XLEN-1:0]                out_pc,
  output logic [INST_BITS-1:0]           out_inst,
  output logic [XLEN-1:0]                out_wdata,
  output logic                           out_rd_valid,
  output logic [RD-1:0]                  out_rd,
  output logic [31:0]                    stall_cycles
);

  localparam int PW    = $clog2(DEPTH) + 1;
  localparam int AW    = PW - 1;
  localparam int BW    = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int REC_W = 2 + 2 * XLEN + INST_BITS + RD;

  typedef logic [REC_W-1:0] rec_t;

  rec_t                  mem [NUM_HARTS][DEPTH];
  logic [PW-1:0]         wr_ptr [NUM_HARTS];
  logic [PW-1:0]         rd_ptr [NUM_HARTS];
  logic [PW-1:0]         cnt    [NUM_HARTS];
  rec_t                  rec_in [NUM_HARTS];
  rec_t                  head   [NUM_HARTS];
  logic [NUM_HARTS-1:0]  full, nonempty, many, push, pop;

  logic [HARTID_LEN-1:0] grant, grant_nxt, rot;
  logic [BW-1:0]         burst_cnt, burst_nxt;
  logic                  found, sel_valid, sel_many, transfer;
  rec_t                  sel_rec;

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      cnt[h]      = wr_ptr[h] - rd_ptr[h];
      full[h]     = (wr_ptr[h][PW-1] != rd_ptr[h][PW-1]) &&
                    (wr_ptr[h][AW-1:0] == rd_ptr[h][AW-1:0]);
      nonempty[h] = (wr_ptr[h] != rd_ptr[h]);
      many[h]     = (cnt[h] >= PW'(2));
      rec_in[h]   = {in_kind[h], in_pc[h*XLEN +: XLEN], in_inst[h*INST_BITS +: INST_BITS],
                     in_wdata[h*XLEN +: XLEN], in_rd_valid[h], in_rd[h*RD +: RD]};
      head[h]     = mem[h][rd_ptr[h][AW-1:0]];
    end
  end

  // in_ready depends only on registered pointers, so a pop this cycle cannot raise it.
  assign in_ready = ~full;
  assign push     = in_valid & ~full;

  always_comb begin
    sel_rec   = '0;
    sel_valid = 1'b0;
    sel_many  = 1'b0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (int'(grant) == h) begin
        sel_rec   = head[h];
        sel_valid = nonempty[h];
        sel_many  = many[h];
      end
    end
  end

  assign out_valid  = sel_valid;
  assign out_hartid = grant;
  assign {out_kind, out_pc, out_inst, out_wdata, out_rd_valid, out_rd} = sel_rec;
  assign transfer   = sel_valid & out_ready;

  always_comb begin
    pop = '0;
    for (int h = 0; h < NUM_HARTS; h++)
      pop[h] = transfer && (int'(grant) == h);
  end

  always_ff @(posedge clock) begin
    for (int h = 0; h < NUM_HARTS; h++)
      if (push[h]) mem[h][wr_ptr[h][AW-1:0]] <= rec_in[h];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        wr_ptr[h] <= '0;
        rd_ptr[h] <= '0;
      end
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (push[h]) wr_ptr[h] <= wr_ptr[h] + PW'(1);
        if (pop[h])  rd_ptr[h] <= rd_ptr[h] + PW'(1);
      end
    end
  end

  // First non-empty hart strictly after grant, in cyclic order; the granted hart is excluded.
  always_comb begin
    found = 1'b0;
    rot   = grant;
    for (int k = 1; k < NUM_HARTS; k++) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (!found && nonempty[h] && (h == (int'(grant) + k) % NUM_HARTS)) begin
          found = 1'b1;
          rot   = HARTID_LEN'(h);
        end
      end
    end
  end

  always_comb begin
    grant_nxt = grant;
    burst_nxt = burst_cnt;
    if (!sel_valid) begin
      if (found) begin
        grant_nxt = rot;
        burst_nxt = '0;
      end
    end else if (transfer) begin
      if (sel_many && (int'(burst_cnt) < BURST - 1)) begin
        burst_nxt = burst_cnt + BW'(1);
      end else begin
        burst_nxt = '0;
        if (found) grant_nxt = rot;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant     <= '0;
      burst_cnt <= '0;
    end else begin
      grant     <= grant_nxt;
      burst_cnt <= burst_nxt;
    end
  end

`ifdef COSIM_COMMIT_ARBITER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((|(in_valid & ~in_ready)) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cosim_commit_arbiter.sv
// Bench for cosim_commit_arbiter: vector table, directed corner sequences, and a randomized
// run against a queue-based reference model of the merge/arbitration rules.
module tb_cosim_commit_arbiter;

  localparam int NH  = 2;
  localparam int XL  = 64;
  localparam int IB  = 32;
  localparam int RDW = 5;
  localparam int DEP = 8;
  localparam int BUR = 2;

  typedef struct packed {
    logic          kind;
    logic [XL-1:0] pc;
    logic [IB-1:0] inst;
    logic [XL-1:0] wdata;
    logic          rdv;
    logic [RDW-1:0] rd;
  } rec_t;

  typedef struct {
    logic          vld;
    logic          kind;
    logic [XL-1:0] pc;
    logic [XL-1:0] wdata;
    logic          ev;
    logic          ekind;
    logic [XL-1:0] epc;
    logic [XL-1:0] ewdata;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NH-1:0]     in_valid, in_ready, in_kind, in_rd_valid;
  logic [XL*NH-1:0]  in_pc, in_wdata;
  logic [IB*NH-1:0]  in_inst;
  logic [RDW*NH-1:0] in_rd;
  logic              out_valid, out_ready;
  logic [0:0]        out_hartid;
  logic              out_kind, out_rd_valid;
  logic [XL-1:0]     out_pc, out_wdata;
  logic [IB-1:0]     out_inst;
  logic [RDW-1:0]    out_rd;
  logic [31:0]       stall_cycles;
  rec_t              out_rec;

  int ncmp = 0;
  int nfail = 0;

  rec_t mq [NH][$];
  int   mg, mb;
  logic [31:0] mstall;

  cosim_commit_arbiter #(
    .NUM_HARTS(NH), .HARTID_LEN(1), .XLEN(XL), .INST_BITS(IB), .RD(RDW), .DEPTH(DEP), .BURST(BUR)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_pc(in_pc),
    .in_inst(in_inst), .in_wdata(in_wdata), .in_rd_valid(in_rd_valid), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_hartid(out_hartid),
    .out_kind(out_kind), .out_pc(out_pc), .out_inst(out_inst), .out_wdata(out_wdata),
    .out_rd_valid(out_rd_valid), .out_rd(out_rd), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  assign out_rec = {out_kind, out_pc, out_inst, out_wdata, out_rd_valid, out_rd};

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic set_rec(input int h, input rec_t r);
    in_kind[h]              = r.kind;
    in_pc[h*XL +: XL]       = r.pc;
    in_inst[h*IB +: IB]     = r.inst;
    in_wdata[h*XL +: XL]    = r.wdata;
    in_rd_valid[h]          = r.rdv;
    in_rd[h*RDW +: RDW]     = r.rd;
  endtask

  function automatic rec_t cur_rec(input int h);
    rec_t r;
    r.kind  = in_kind[h];
    r.pc    = in_pc[h*XL +: XL];
    r.inst  = in_inst[h*IB +: IB];
    r.wdata = in_wdata[h*XL +: XL];
    r.rdv   = in_rd_valid[h];
    r.rd    = in_rd[h*RDW +: RDW];
    return r;
  endfunction

  function automatic rec_t mk(input logic kind, input logic [XL-1:0] pc, input logic [XL-1:0] wd);
    rec_t r;
    r.kind = kind; r.pc = pc; r.inst = 32'h0000_0013; r.wdata = wd; r.rdv = ~kind; r.rd = 5'd1;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int h = 0; h < NH; h++) mq[h].delete();
    mg = 0; mb = 0; mstall = '0;
  endtask

  // Reference: one clock edge of the merge rules, computed from queue occupancies before the edge.
  task automatic model_step();
    int sz [NH];
    int g0, nx;
    bit mv, xf, fnd, stl;
    for (int h = 0; h < NH; h++) sz[h] = mq[h].size();
    g0 = mg;
    mv = sz[g0] > 0;
    xf = mv && out_ready;
    fnd = 0; nx = g0;
    for (int k = 1; k < NH; k++)
      if (!fnd && sz[(g0 + k) % NH] > 0) begin fnd = 1; nx = (g0 + k) % NH; end
    if (!mv) begin
      if (fnd) begin mg = nx; mb = 0; end
    end else if (xf) begin
      if (sz[g0] >= 2 && mb < BUR - 1) mb++;
      else begin mb = 0; if (fnd) mg = nx; end
    end
    if (xf) void'(mq[g0].pop_front());
    stl = 0;
    for (int h = 0; h < NH; h++) begin
      if (in_valid[h] && sz[h] < DEP) mq[h].push_back(cur_rec(h));
      if (in_valid[h] && sz[h] >= DEP) stl = 1;
    end
    if (stl && mstall != 32'hFFFF_FFFF) mstall++;
  endtask

  vec_t tbl [8];
  logic [XL-1:0] cause;

  initial begin
    in_valid = '0; in_kind = '0; in_pc = '0; in_inst = '0; in_wdata = '0;
    in_rd_valid = '0; in_rd = '0; out_ready = 1'b0;
    cause = 64'h8000_0000_0000_0007;

    tbl[0] = '{1'b1, 1'b0, 64'h8000_0000, 64'h11, 1'b1, 1'b0, 64'h8000_0000, 64'h11};
    tbl[1] = '{1'b1, 1'b0, 64'h8000_0004, 64'h22, 1'b1, 1'b0, 64'h8000_0004, 64'h22};
    tbl[2] = '{1'b1, 1'b0, 64'h8000_0008, 64'h33, 1'b1, 1'b0, 64'h8000_0008, 64'h33};
    tbl[3] = '{1'b0, 1'b0, 64'h0,         64'h0,  1'b0, 1'b0, 64'h0,         64'h0};
    tbl[4] = '{1'b1, 1'b0, 64'h8000_0100, 64'h44, 1'b1, 1'b0, 64'h8000_0100, 64'h44};
    tbl[5] = '{1'b1, 1'b0, 64'h8000_0104, 64'h55, 1'b1, 1'b0, 64'h8000_0104, 64'h55};
    tbl[6] = '{1'b1, 1'b1, 64'h8000_0108, cause,  1'b1, 1'b1, 64'h8000_0108, cause};
    tbl[7] = '{1'b0, 1'b0, 64'h0,         64'h0,  1'b0, 1'b0, 64'h0,         64'h0};

    // Reset state
    do_reset();
    check("reset_out_valid", 192'(out_valid), 192'(1'b0));
    check("reset_in_ready", 192'(in_ready), 192'(2'b11));
    check("reset_stall", 192'(stall_cycles), 192'(32'd0));

    // Vector table: hart 0 back-to-back commits, then commit/commit/trap
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid[0] = tbl[i].vld;
      set_rec(0, mk(tbl[i].kind, tbl[i].pc, tbl[i].wdata));
      @(negedge clock);
      check($sformatf("tbl%0d_valid", i), 192'(out_valid), 192'(tbl[i].ev));
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_hartid", i), 192'(out_hartid), 192'(1'b0));
        check($sformatf("tbl%0d_pc", i), 192'(out_pc), 192'(tbl[i].epc));
        check($sformatf("tbl%0d_kind", i), 192'(out_kind), 192'(tbl[i].ekind));
        check($sformatf("tbl%0d_wdata", i), 192'(out_wdata), 192'(tbl[i].ewdata));
      end
    end
    in_valid = '0;

    // Bounded burst: both harts preloaded with 6 records
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 2'b11;
      set_rec(0, mk(1'b0, 64'(i), 64'h0));
      set_rec(1, mk(1'b0, 64'h1000 + 64'(i), 64'h0));
      @(negedge clock);
    end
    in_valid = '0;
    out_ready = 1'b1;
    begin
      int idx [NH];
      int eh;
      idx[0] = 0; idx[1] = 0;
      for (int k = 0; k < 12; k++) begin
        eh = (k / 2) % 2;
        check($sformatf("burst%0d_valid", k), 192'(out_valid), 192'(1'b1));
        check($sformatf("burst%0d_hartid", k), 192'(out_hartid), 192'(eh));
        check($sformatf("burst%0d_pc", k), 192'(out_pc), 192'(64'h1000 * 64'(eh) + 64'(idx[eh])));
        idx[eh]++;
        @(negedge clock);
      end
    end
    check("burst_drained", 192'(out_valid), 192'(1'b0));

    // Full FIFO with the consumer stalled: in_ready falls after 8 pushes, output holds
    do_reset();
    in_valid = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      set_rec(1, mk(1'b0, 64'h2000 + 64'(i - 1), 64'h0));
      @(negedge clock);
      check($sformatf("full%0d_in_ready1", i), 192'(in_ready[1]), 192'((i < 8) ? 1'b1 : 1'b0));
      if (i >= 2) begin
        check($sformatf("hold%0d_valid", i), 192'(out_valid), 192'(1'b1));
        check($sformatf("hold%0d_pc", i), 192'(out_pc), 192'(64'h2000));
        check($sformatf("hold%0d_hartid", i), 192'(out_hartid), 192'(1'b1));
      end
    end
    in_valid = '0;
    out_ready = 1'b1;
    #1 check("full_pop_same_cycle_ready", 192'(in_ready[1]), 192'(1'b0));
    @(negedge clock);
    out_ready = 1'b0;
    check("full_pop_next_ready", 192'(in_ready[1]), 192'(1'b1));
    check("full_pop_next_pc", 192'(out_pc), 192'(64'h2001));

    // Stall counter: hart 0 holds in_valid against a full FIFO for 10 cycles
    do_reset();
    in_valid = 2'b01;
    set_rec(0, mk(1'b0, 64'h3000, 64'h0));
    repeat (18) @(negedge clock);
    in_valid = '0;
`ifdef COSIM_COMMIT_ARBITER_STALL_CNT_EN
    check("stall_count", 192'(stall_cycles), 192'(32'd10));
    @(negedge clock);
    check("stall_hold", 192'(stall_cycles), 192'(32'd10));
`else
    check("stall_count_off", 192'(stall_cycles), 192'(32'd0));
    @(negedge clock);
    check("stall_hold_off", 192'(stall_cycles), 192'(32'd0));
`endif

    // Asynchronous reset in the middle of a burst with 5 records queued
    do_reset();
    in_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      set_rec(0, mk(1'b0, 64'h4000 + 64'(i), 64'h0));
      @(negedge clock);
    end
    in_valid = '0;
    out_ready = 1'b1;
    @(negedge clock);
    check("mid_burst_valid", 192'(out_valid), 192'(1'b1));
    #2 reset = 1'b1;
    #1 check("async_reset_valid", 192'(out_valid), 192'(1'b0));
    check("async_reset_in_ready", 192'(in_ready), 192'(2'b11));
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("post_reset%0d_valid", i), 192'(out_valid), 192'(1'b0));
      check($sformatf("post_reset%0d_grant", i), 192'(out_hartid), 192'(1'b0));
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [NH-1:0] er;
      int pr;
      for (int h = 0; h < NH; h++) er[h] = (mq[h].size() < DEP);
      check("rnd_in_ready", 192'(in_ready), 192'(er));
      check("rnd_valid", 192'(out_valid), 192'(mq[mg].size() > 0));
      if (mq[mg].size() > 0) begin
        check("rnd_hartid", 192'(out_hartid), 192'(mg));
        check("rnd_record", 192'(out_rec), 192'(mq[mg][0]));
      end
`ifdef COSIM_COMMIT_ARBITER_STALL_CNT_EN
      check("rnd_stall", 192'(stall_cycles), 192'(mstall));
`else
      check("rnd_stall_off", 192'(stall_cycles), 192'(32'd0));
`endif
      pr = ((cyc / 300) % 3 == 0) ? 20 : (((cyc / 300) % 3 == 1) ? 60 : 95);
      out_ready = ($urandom_range(0, 99) < pr);
      for (int h = 0; h < NH; h++) begin
        rec_t r;
        in_valid[h] = ($urandom_range(0, 99) < 55);
        r.kind  = ($urandom_range(0, 7) == 0);
        r.pc    = {$urandom, $urandom};
        r.inst  = $urandom;
        r.wdata = {$urandom, $urandom};
        r.rdv   = $urandom_range(0, 1);
        r.rd    = 5'($urandom_range(0, 31));
        set_rec(h, r);
      end
      model_step();
      @(negedge clock);
    end
    in_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
